// File: rtl/encrypter_collector.sv
// Output-side scheduler: collects finished blocks from the encrypter bank in strict
// round-robin order and serializes each one MSB-nibble-first onto a 4-bit QSPI link.
module encrypter_collector #(
    parameter int unsigned NUM_ENCRYPTERS  = 4,
    parameter int unsigned ENCRYPTER_WIDTH = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] enc_data,
    input  logic [NUM_ENCRYPTERS-1:0]                 enc_valid,
    output logic [NUM_ENCRYPTERS-1:0]                 enc_ack,
    input  logic                                      flush,
    output logic [3:0]                                qspi_out_data,
    output logic                                      qspi_out_valid,
    input  logic                                      qspi_out_ready,
    output logic [1:0]                                state_out,
    output logic [15:0]                               blocks_out
);

    localparam int unsigned W       = ENCRYPTER_WIDTH;
    localparam int unsigned NIBBLES = W / 4;
    localparam int unsigned PTR_W   = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;
    localparam int unsigned CNT_W   = $clog2(NIBBLES) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t                    state_q, state_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [W-1:0]              shift_q, shift_d;
    logic [NUM_ENCRYPTERS-1:0] ack_q, ack_d;
    logic                      valid_q, valid_d;
    logic [3:0]                data_q, data_d;
    logic [15:0]               blocks_q, blocks_d;

    logic [W-1:0]              sel_data;
    logic                      sel_valid;
    logic [W-1:0]              shifted;

    // Only the encrypter at the round-robin pointer is visible to the FSM.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_ENCRYPTERS; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                sel_data  = enc_data[i*W +: W];
                sel_valid = enc_valid[i];
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        ack_d    = '0;
        valid_d  = valid_q;
        data_d   = data_q;
        blocks_d = blocks_q;
        shifted  = shift_q << 4;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                data_d  = 4'h0;
                if (sel_valid) begin
                    shift_d = sel_data;
                    ack_d   = NUM_ENCRYPTERS'(1) << ptr_q;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    data_d  = sel_data[W-1 -: 4];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (valid_q && qspi_out_ready) begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                        valid_d = 1'b0;
                        data_d  = 4'h0;
                        state_d = DONE;
                    end else begin
                        data_d  = shifted[W-1 -: 4];
                    end
                end
            end
            DONE: begin
                valid_d  = 1'b0;
                data_d   = 4'h0;
                ptr_d    = (ptr_q == PTR_W'(NUM_ENCRYPTERS - 1)) ? '0 : ptr_q + PTR_W'(1);
                blocks_d = blocks_q + 16'd1;
                state_d  = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                data_d  = 4'h0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Restart overrides everything; the in-flight block is dropped.
        if (flush) begin
            state_d  = IDLE;
            ptr_d    = '0;
            cnt_d    = '0;
            shift_d  = '0;
            ack_d    = '0;
            valid_d  = 1'b0;
            data_d   = 4'h0;
            blocks_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            ack_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= 4'h0;
            blocks_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            blocks_q <= blocks_d;
        end
    end

    assign enc_ack        = ack_q;
    assign qspi_out_valid = valid_q;
    assign qspi_out_data  = data_q;
    assign state_out      = state_q;
    assign blocks_out     = blocks_q;

endmodule

// File: tb/tb_encrypter_collector.sv
// Scoreboard bench for encrypter_collector: expected acks and nibbles are queued by
// the stimulus and consumed by an independent monitor as the DUT presents them.
module tb_encrypter_collector;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 32;
    localparam int unsigned NIB = W / 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] enc_data;
    logic [N-1:0]   enc_valid;
    logic [N-1:0]   enc_ack;
    logic           flush;
    logic [3:0]     qspi_out_data;
    logic           qspi_out_valid;
    logic           qspi_out_ready;
    logic [1:0]     state_out;
    logic [15:0]    blocks_out;

    always #5 clk = ~clk;

    encrypter_collector #(.NUM_ENCRYPTERS(N), .ENCRYPTER_WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .enc_data       (enc_data),
        .enc_valid      (enc_valid),
        .enc_ack        (enc_ack),
        .flush          (flush),
        .qspi_out_data  (qspi_out_data),
        .qspi_out_valid (qspi_out_valid),
        .qspi_out_ready (qspi_out_ready),
        .state_out      (state_out),
        .blocks_out     (blocks_out)
    );

    typedef struct {
        int idx;
        int nib_before;
    } ack_exp_t;

    ack_exp_t   ack_q[$];
    logic [3:0] nib_q[$];
    int         nib_pushed = 0;
    int         nib_seen   = 0;
    int         checks     = 0;
    int         fails      = 0;
    logic       hold_pend  = 1'b0;
    logic       prev_flush = 1'b0;
    logic [3:0] hold_data  = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_block(input int idx, input logic [31:0] d, input int nnib);
        ack_exp_t e;
        e.idx        = idx;
        e.nib_before = nib_pushed;
        ack_q.push_back(e);
        for (int n = 0; n < nnib; n++) nib_q.push_back(d[31-4*n -: 4]);
        nib_pushed += nnib;
    endtask

    task automatic set_slice(input int idx, input logic [31:0] d);
        enc_data[idx*W +: W] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_blocks", 32'(blocks_out), 32'd0);
        chk("flush_state", 32'(state_out), 32'd0);
    endtask

    task automatic wait_blocks(input int n, input int budget, output int cyc);
        cyc = 0;
        while (blocks_out != 16'(n) && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("blocks_reached", 32'(blocks_out), 32'(n));
    endtask

    task automatic wait_nibs(input int n, input int budget);
        int c = 0;
        while (nib_seen < n && c < budget) begin
            @(negedge clk);
            #2;
            c++;
        end
        chk("nib_wait", 32'(nib_seen), 32'(n));
    endtask

    // Encrypter model: drop valid once the ack has been seen.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++)
            if (enc_ack[i]) enc_valid[i] = 1'b0;
    end

    // Monitor: ack order, nibble stream, hold-while-stalled, idle data zero.
    always @(negedge clk) begin
        ack_exp_t   e;
        logic [3:0] en;
        if (reset) begin
            if (enc_ack != '0) begin
                chk("ack_onehot", 32'($onehot(enc_ack)), 32'd1);
                if (ack_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL ack_unexpected: got %b expected none", enc_ack);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_index", 32'(enc_ack), 32'(1 << e.idx));
                    chk("ack_after_nibbles", 32'(nib_seen), 32'(e.nib_before));
                end
            end
            if (!qspi_out_valid) chk("idle_data_zero", 32'(qspi_out_data), 32'd0);
            if (hold_pend && !prev_flush) begin
                chk("hold_valid", 32'(qspi_out_valid), 32'd1);
                chk("hold_data", 32'(qspi_out_data), 32'(hold_data));
            end
            if (qspi_out_valid && qspi_out_ready) begin
                if (nib_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL nib_unexpected: got %h expected none", qspi_out_data);
                end else begin
                    en = nib_q.pop_front();
                    chk("nibble", 32'(qspi_out_data), 32'(en));
                end
                nib_seen++;
            end
            hold_pend  = qspi_out_valid && !qspi_out_ready;
            hold_data  = qspi_out_data;
            prev_flush = flush;
        end else begin
            hold_pend  = 1'b0;
            prev_flush = 1'b0;
        end
    end

    initial begin
        int cyc;
        reset          = 1'b0;
        flush          = 1'b0;
        enc_valid      = '1;
        enc_data       = '0;
        qspi_out_ready = 1'b0;

        // Reset held with all encrypters valid.
        repeat (4) begin
            @(negedge clk);
            chk("rst_ack", 32'(enc_ack), 32'd0);
            chk("rst_valid", 32'(qspi_out_valid), 32'd0);
            chk("rst_state", 32'(state_out), 32'd0);
            chk("rst_blocks", 32'(blocks_out), 32'd0);
        end
        enc_valid = '0;
        tick();
        reset = 1'b1;
        tick();

        // Single block, ready always high.
        set_slice(0, 32'hA1B2C3D4);
        push_block(0, 32'hA1B2C3D4, NIB);
        qspi_out_ready = 1'b1;
        enc_valid[0]   = 1'b1;
        wait_blocks(1, 40, cyc);
        chk("single_latency", 32'(cyc), 32'(NIB + 2));
        enc_valid[0] = 1'b1;
        repeat (6) tick();
        chk("single_no_recapture_state", 32'(state_out), 32'd0);
        chk("single_blocks", 32'(blocks_out), 32'd1);
        enc_valid[0] = 1'b0;

        // Out-of-order readiness still drains in round-robin order.
        do_flush();
        set_slice(0, 32'h00000000);
        set_slice(1, 32'h11111111);
        set_slice(2, 32'h22222222);
        push_block(0, 32'h00000000, NIB);
        push_block(1, 32'h11111111, NIB);
        push_block(2, 32'h22222222, NIB);
        enc_valid[2] = 1'b1;
        repeat (3) tick();
        enc_valid[1] = 1'b1;
        repeat (3) tick();
        enc_valid[0] = 1'b1;
        wait_blocks(3, 100, cyc);

        // Backpressure with ready pattern 1,0,0.
        do_flush();
        set_slice(0, 32'h12345678);
        push_block(0, 32'h12345678, NIB);
        enc_valid[0] = 1'b1;
        cyc = 0;
        while (blocks_out != 16'd1 && cyc < 80) begin
            qspi_out_ready = (cyc % 3 == 0);
            tick();
            cyc++;
        end
        chk("bp_blocks", 32'(blocks_out), 32'd1);
        qspi_out_ready = 1'b1;

        // Wrap-around: captures 0,1,2,3,0.
        do_flush();
        for (int i = 0; i < N; i++) set_slice(i, 32'hC0DEF000 + 32'(i) * 32'h111);
        for (int i = 0; i < 5; i++) push_block(i % N, 32'hC0DEF000 + 32'(i % N) * 32'h111, NIB);
        enc_valid = '1;
        wait_blocks(1, 40, cyc);
        enc_valid[0] = 1'b1;
        wait_blocks(5, 100, cyc);
        repeat (4) tick();
        chk("wrap_blocks", 32'(blocks_out), 32'd5);
        chk("wrap_state", 32'(state_out), 32'd0);

        // Flush after three nibbles.
        do_flush();
        set_slice(0, 32'hDEADBEEF);
        push_block(0, 32'hDEADBEEF, 3);
        enc_valid[0] = 1'b1;
        wait_nibs(nib_pushed, 40);
        tick();
        flush          = 1'b1;
        qspi_out_ready = 1'b0;
        tick();
        flush = 1'b0;
        chk("flush_mid_valid", 32'(qspi_out_valid), 32'd0);
        chk("flush_mid_ack", 32'(enc_ack), 32'd0);
        chk("flush_mid_blocks", 32'(blocks_out), 32'd0);
        chk("flush_mid_state", 32'(state_out), 32'd0);
        set_slice(1, 32'h13579BDF);
        enc_valid[1] = 1'b1;
        repeat (4) tick();
        chk("flush_ptr_zero_state", 32'(state_out), 32'd0);
        qspi_out_ready = 1'b1;
        set_slice(0, 32'h2468ACE0);
        push_block(0, 32'h2468ACE0, NIB);
        push_block(1, 32'h13579BDF, NIB);
        enc_valid[0] = 1'b1;
        wait_blocks(2, 60, cyc);

        // Asynchronous reset in the middle of a block.
        set_slice(2, 32'h98765432);
        push_block(2, 32'h98765432, 2);
        enc_valid[2] = 1'b1;
        wait_nibs(nib_pushed, 40);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(qspi_out_valid), 32'd0);
        chk("arst_data", 32'(qspi_out_data), 32'd0);
        chk("arst_ack", 32'(enc_ack), 32'd0);
        chk("arst_state", 32'(state_out), 32'd0);
        chk("arst_blocks", 32'(blocks_out), 32'd0);
        enc_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        set_slice(0, 32'h0F1E2D3C);
        push_block(0, 32'h0F1E2D3C, NIB);
        enc_valid[0] = 1'b1;
        wait_blocks(1, 40, cyc);
        repeat (3) tick();
        chk("queues_drained", 32'(nib_q.size() + ack_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
